border_bounce_ctrl: RTL and testbench
=====================================

// Module: border_bounce_ctrl
// PURPOSE
//  Multi-ball table-border collision handler in HIT_CONTROLLER. Per frame, detects
//  each ball's overlap with the border drawing request and classifies the hit
//  edge(s) from position. Forces the velocity component toward the table interior
//  with optional damping, then holds the result until the next frame update.
//  Sits between the ball objects and the physics/velocity update logic.
// PARAMETERS
//  NUM_BALLS     4    number of independent ball channels
//  WIDTH         11   signed width of positions/velocities
//  BALL_SIZE     32   ball bounding-box side, pixels
//  TOP_OFFSET    32   inner Y of top border
//  DOWN_OFFSET   448  inner Y of bottom border
//  LEFT_OFFSET   32   inner X of left border
//  RIGHT_OFFSET  608  inner X of right border
//  DAMP_SHIFT    3    bounce speed loss = |v|>>>DAMP_SHIFT; 0 = no damping
//  REARM_MARGIN  2    px ball must be clear of every border before re-arming
// PORTS
//  clk               in   1                 system clock
//  resetN            in   1                 async active-low reset
//  startOfFrame      in   1                 1-cycle pulse, physics consumes velocities
//  ballDR            in   NUM_BALLS         per-ball drawing request
//  bordersDR         in   1                 border drawing request
//  ballPosX/ballPosY in   NUM_BALLS*WIDTH   packed signed top-left positions, ch i at [i*WIDTH+:WIDTH]
//  ballVelX/ballVelY in   NUM_BALLS*WIDTH   packed signed current velocities
//  ballVelXOut/YOut  out  NUM_BALLS*WIDTH   packed signed corrected velocities
//  collisionOccurred out  NUM_BALLS         1-cycle pulse per detected hit
//  hitEdge           out  NUM_BALLS*4       {top,down,left,right} of last hit, held
// BEHAVIOUR
//  Reset (async, resetN=0): all FSMs ARMED, pending flags 0, all outputs 0.
//  Per-channel FSM, channels fully independent:
//   ARMED   : ballDR[i] & bordersDR -> evaluate edges, pulse collisionOccurred[i]
//             next cycle, load hitEdge[i], go LATCHED.
//   LATCHED : no further hits; -> ARMED when X>LEFT+M, X+SIZE<RIGHT-M,
//             Y>TOP+M, Y+SIZE<DOWN-M (all four true; M=REARM_MARGIN).
//  Edge classification (signed compare, sums in WIDTH+1 bits):
//   left = X<=LEFT_OFFSET; right = X+BALL_SIZE>=RIGHT_OFFSET;
//   top = Y<=TOP_OFFSET; down = Y+BALL_SIZE>=DOWN_OFFSET.
//   Hit with no edge true (interior artefact): pulse still issued, velocity unchanged.
//  Reflection per axis: mag=|v| (v=-2^(WIDTH-1) saturates to 2^(WIDTH-1)-1);
//   mag' = mag - (mag>>>DAMP_SHIFT) (DAMP_SHIFT=0 -> mag'=mag).
//   left/top -> +mag'; right/down -> -mag'. Sign forced, never negated, so no
//   double-flip. Both X edges true (impossible geometry): X unchanged.
//  Pending: hit on an axis sets pendX/pendY[i] and stores the reflected value;
//   startOfFrame clears pending. Hit and startOfFrame in the same cycle: hit wins
//   (pending set, new value stored).
//  Outputs registered, latency 1: VelOut = pend ? stored : VelIn.
//  Corner hit sets both axes in the same cycle.
//  Reset mid-operation: all pending/state discarded immediately.
// TESTING
//  1 Ball0 X=30,Y=200,VelX=-8, DR pulse -> next cycle pulse[0]=1, hitEdge=0010,
//    VelXOut=+7, VelYOut=VelY.
//  2 DAMP_SHIFT=0, X=600(+32>=608), VelX=+5 -> VelXOut=-5 held until
//    startOfFrame, then follows VelX.
//  3 Corner X=30,Y=30, VelX=-4,VelY=-16 -> hitEdge=1010, outputs +4,+14.
//  4 Repeat DR while ball still at X=31 -> no second pulse. Move to X=40 -> ARMED;
//    new hit pulses again.
//  5 Balls 0 and 3 hit in the same cycle as startOfFrame -> both pulse,
//    both pending; ball1/2 pass through.
//  6 VelX=-1024 left hit, DAMP_SHIFT=3 -> +896. resetN low mid-hold ->
//    outputs 0, FSM ARMED.

Source files
------------

// File: rtl/border_bounce_ctrl.sv
// Multi-ball table-border collision handler: per-ball hit detection, edge
// classification and sign-forced, optionally damped velocity reflection.
module border_bounce_ctrl #(
    parameter int NUM_BALLS    = 4,
    parameter int WIDTH        = 11,
    parameter int BALL_SIZE    = 32,
    parameter int TOP_OFFSET   = 32,
    parameter int DOWN_OFFSET  = 448,
    parameter int LEFT_OFFSET  = 32,
    parameter int RIGHT_OFFSET = 608,
    parameter int DAMP_SHIFT   = 3,
    parameter int REARM_MARGIN = 2
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       startOfFrame,
    input  logic [NUM_BALLS-1:0]       ballDR,
    input  logic                       bordersDR,
    input  logic [NUM_BALLS*WIDTH-1:0] ballPosX,
    input  logic [NUM_BALLS*WIDTH-1:0] ballPosY,
    input  logic [NUM_BALLS*WIDTH-1:0] ballVelX,
    input  logic [NUM_BALLS*WIDTH-1:0] ballVelY,
    output logic [NUM_BALLS*WIDTH-1:0] ballVelXOut,
    output logic [NUM_BALLS*WIDTH-1:0] ballVelYOut,
    output logic [NUM_BALLS-1:0]       collisionOccurred,
    output logic [NUM_BALLS*4-1:0]     hitEdge
);

    typedef enum logic {ST_ARMED, ST_LATCHED} state_t;

    localparam logic signed [WIDTH:0]   C_SIZE    = (WIDTH+1)'(BALL_SIZE);
    localparam logic signed [WIDTH:0]   C_TOP     = (WIDTH+1)'(TOP_OFFSET);
    localparam logic signed [WIDTH:0]   C_DOWN    = (WIDTH+1)'(DOWN_OFFSET);
    localparam logic signed [WIDTH:0]   C_LEFT    = (WIDTH+1)'(LEFT_OFFSET);
    localparam logic signed [WIDTH:0]   C_RIGHT   = (WIDTH+1)'(RIGHT_OFFSET);
    localparam logic signed [WIDTH:0]   C_TOP_M   = (WIDTH+1)'(TOP_OFFSET + REARM_MARGIN);
    localparam logic signed [WIDTH:0]   C_DOWN_M  = (WIDTH+1)'(DOWN_OFFSET - REARM_MARGIN);
    localparam logic signed [WIDTH:0]   C_LEFT_M  = (WIDTH+1)'(LEFT_OFFSET + REARM_MARGIN);
    localparam logic signed [WIDTH:0]   C_RIGHT_M = (WIDTH+1)'(RIGHT_OFFSET - REARM_MARGIN);
    localparam logic signed [WIDTH-1:0] V_MIN     = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] V_MAX     = {1'b0, {(WIDTH-1){1'b1}}};

    // Magnitude saturates at the most negative code so the result always fits.
    function automatic logic signed [WIDTH-1:0] reflect(
        input logic signed [WIDTH-1:0] v,
        input logic                    to_pos
    );
        logic signed [WIDTH-1:0] mag;
        logic signed [WIDTH-1:0] mp;
        if (v == V_MIN)
            mag = V_MAX;
        else
            mag = (v < 0) ? -v : v;
        if (DAMP_SHIFT == 0)
            mp = mag;
        else
            mp = mag - (mag >>> DAMP_SHIFT);
        return to_pos ? mp : -mp;
    endfunction

    for (genvar g = 0; g < NUM_BALLS; g++) begin : g_ch
        logic signed [WIDTH-1:0] w_px, w_py, w_vx, w_vy;
        logic signed [WIDTH:0]   w_xl, w_xr, w_yt, w_yb;
        logic                    w_left, w_right, w_top, w_down, w_clear, w_hit;
        logic                    w_pendX_nxt, w_pendY_nxt;
        logic signed [WIDTH-1:0] w_storeX_nxt, w_storeY_nxt;

        state_t                  r_state;
        logic                    r_pendX, r_pendY, r_coll;
        logic [3:0]              r_edge;
        logic signed [WIDTH-1:0] r_storeX, r_storeY, r_velXOut, r_velYOut;

        assign w_px = ballPosX[g*WIDTH +: WIDTH];
        assign w_py = ballPosY[g*WIDTH +: WIDTH];
        assign w_vx = ballVelX[g*WIDTH +: WIDTH];
        assign w_vy = ballVelY[g*WIDTH +: WIDTH];

        assign w_xl = {w_px[WIDTH-1], w_px};
        assign w_yt = {w_py[WIDTH-1], w_py};
        assign w_xr = w_xl + C_SIZE;
        assign w_yb = w_yt + C_SIZE;

        assign w_left  = (w_xl <= C_LEFT);
        assign w_right = (w_xr >= C_RIGHT);
        assign w_top   = (w_yt <= C_TOP);
        assign w_down  = (w_yb >= C_DOWN);
        assign w_clear = (w_xl > C_LEFT_M) && (w_xr < C_RIGHT_M) &&
                         (w_yt > C_TOP_M)  && (w_yb < C_DOWN_M);
        assign w_hit   = (r_state == ST_ARMED) && ballDR[g] && bordersDR;

        // A hit in the same cycle as startOfFrame re-arms pending for the next frame.
        always_comb begin
            w_pendX_nxt  = r_pendX & ~startOfFrame;
            w_pendY_nxt  = r_pendY & ~startOfFrame;
            w_storeX_nxt = r_storeX;
            w_storeY_nxt = r_storeY;
            if (w_hit && (w_left ^ w_right)) begin
                w_pendX_nxt  = 1'b1;
                w_storeX_nxt = reflect(w_vx, w_left);
            end
            if (w_hit && (w_top ^ w_down)) begin
                w_pendY_nxt  = 1'b1;
                w_storeY_nxt = reflect(w_vy, w_top);
            end
        end

        always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
                r_state   <= ST_ARMED;
                r_pendX   <= 1'b0;
                r_pendY   <= 1'b0;
                r_coll    <= 1'b0;
                r_edge    <= 4'b0000;
                r_storeX  <= '0;
                r_storeY  <= '0;
                r_velXOut <= '0;
                r_velYOut <= '0;
            end else begin
                r_coll <= 1'b0;
                case (r_state)
                    ST_ARMED: begin
                        if (w_hit) begin
                            r_coll  <= 1'b1;
                            r_edge  <= {w_top, w_down, w_left, w_right};
                            r_state <= ST_LATCHED;
                        end
                    end
                    ST_LATCHED: begin
                        if (w_clear)
                            r_state <= ST_ARMED;
                    end
                    default: r_state <= ST_ARMED;
                endcase
                r_pendX   <= w_pendX_nxt;
                r_pendY   <= w_pendY_nxt;
                r_storeX  <= w_storeX_nxt;
                r_storeY  <= w_storeY_nxt;
                r_velXOut <= w_pendX_nxt ? w_storeX_nxt : w_vx;
                r_velYOut <= w_pendY_nxt ? w_storeY_nxt : w_vy;
            end
        end

        assign ballVelXOut[g*WIDTH +: WIDTH] = r_velXOut;
        assign ballVelYOut[g*WIDTH +: WIDTH] = r_velYOut;
        assign collisionOccurred[g]          = r_coll;
        assign hitEdge[g*4 +: 4]             = r_edge;
    end

endmodule

// File: tb/tb_border_bounce_ctrl.sv
// Bench for border_bounce_ctrl: a damped (shift 3) and an undamped (shift 0)
// instance share stimulus; a behavioural model feeds an expected-value queue.
module tb_border_bounce_ctrl;
    localparam int NB = 4;
    localparam int W  = 11;

    logic              clk = 1'b0;
    logic              resetN, startOfFrame, bordersDR;
    logic [NB-1:0]     ballDR;
    logic [NB*W-1:0]   posX, posY, velX, velY;
    logic [NB*W-1:0]   vxo3, vyo3, vxo0, vyo0;
    logic [NB-1:0]     coll3, coll0;
    logic [NB*4-1:0]   edge3, edge0;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [NB*W-1:0] vx3, vy3, vx0, vy0;
        logic [NB-1:0]   coll;
        logic [NB*4-1:0] edg;
    } exp_t;
    exp_t sb[$];

    bit         m_armed[NB];
    bit         m_pX[NB], m_pY[NB];
    int         m_sX3[NB], m_sX0[NB], m_sY3[NB], m_sY0[NB];
    logic [3:0] m_edge[NB];

    border_bounce_ctrl #(.DAMP_SHIFT(3)) u_dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .ballDR(ballDR),
        .bordersDR(bordersDR), .ballPosX(posX), .ballPosY(posY), .ballVelX(velX),
        .ballVelY(velY), .ballVelXOut(vxo3), .ballVelYOut(vyo3),
        .collisionOccurred(coll3), .hitEdge(edge3)
    );

    border_bounce_ctrl #(.DAMP_SHIFT(0)) u_dut0 (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .ballDR(ballDR),
        .bordersDR(bordersDR), .ballPosX(posX), .ballPosY(posY), .ballVelX(velX),
        .ballVelY(velY), .ballVelXOut(vxo0), .ballVelYOut(vyo0),
        .collisionOccurred(coll0), .hitEdge(edge0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int sgn(input logic [W-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic int refl(input int v, input int sh, input bit pos);
        int mag, mp;
        mag = (v < 0) ? -v : v;
        if (mag > 1023) mag = 1023;
        mp = (sh == 0) ? mag : mag - (mag >> sh);
        return pos ? mp : -mp;
    endfunction

    task automatic model_step();
        exp_t e;
        for (int i = 0; i < NB; i++) begin
            if (!resetN) begin
                m_armed[i] = 1'b1;
                m_pX[i] = 1'b0;
                m_pY[i] = 1'b0;
                m_edge[i] = 4'b0000;
                e.vx3[i*W +: W] = '0;
                e.vy3[i*W +: W] = '0;
                e.vx0[i*W +: W] = '0;
                e.vy0[i*W +: W] = '0;
                e.coll[i] = 1'b0;
                e.edg[i*4 +: 4] = 4'b0000;
            end else begin
                int x, y, vx, vy;
                bit l, r, t, d, hit, clr;
                x  = sgn(posX[i*W +: W]);
                y  = sgn(posY[i*W +: W]);
                vx = sgn(velX[i*W +: W]);
                vy = sgn(velY[i*W +: W]);
                l = (x <= 32);
                r = (x + 32 >= 608);
                t = (y <= 32);
                d = (y + 32 >= 448);
                clr = (x > 34) && (x + 32 < 606) && (y > 34) && (y + 32 < 446);
                hit = m_armed[i] && ballDR[i] && bordersDR;
                if (hit) begin
                    m_edge[i]  = {t, d, l, r};
                    m_armed[i] = 1'b0;
                end else if (!m_armed[i] && clr) begin
                    m_armed[i] = 1'b1;
                end
                if (startOfFrame) begin
                    m_pX[i] = 1'b0;
                    m_pY[i] = 1'b0;
                end
                if (hit && (l != r)) begin
                    m_pX[i]  = 1'b1;
                    m_sX3[i] = refl(vx, 3, l);
                    m_sX0[i] = refl(vx, 0, l);
                end
                if (hit && (t != d)) begin
                    m_pY[i]  = 1'b1;
                    m_sY3[i] = refl(vy, 3, t);
                    m_sY0[i] = refl(vy, 0, t);
                end
                e.vx3[i*W +: W] = m_pX[i] ? W'(m_sX3[i]) : W'(vx);
                e.vx0[i*W +: W] = m_pX[i] ? W'(m_sX0[i]) : W'(vx);
                e.vy3[i*W +: W] = m_pY[i] ? W'(m_sY3[i]) : W'(vy);
                e.vy0[i*W +: W] = m_pY[i] ? W'(m_sY0[i]) : W'(vy);
                e.coll[i] = hit;
                e.edg[i*4 +: 4] = m_edge[i];
            end
        end
        sb.push_back(e);
    endtask

    // Drive happens before the call; outputs are sampled on the following negedge.
    task automatic cycle();
        exp_t e;
        model_step();
        @(negedge clk);
        e = sb.pop_front();
        check("vx_d3", vxo3, e.vx3);
        check("vy_d3", vyo3, e.vy3);
        check("vx_d0", vxo0, e.vx0);
        check("vy_d0", vyo0, e.vy0);
        check("coll_d3", coll3, e.coll);
        check("coll_d0", coll0, e.coll);
        check("edge_d3", edge3, e.edg);
        check("edge_d0", edge0, e.edg);
    endtask

    task automatic set_ball(input int i, input int x, input int y, input int vx, input int vy);
        posX[i*W +: W] = W'(x);
        posY[i*W +: W] = W'(y);
        velX[i*W +: W] = W'(vx);
        velY[i*W +: W] = W'(vy);
    endtask

    initial begin
        resetN = 1'b0;
        startOfFrame = 1'b0;
        bordersDR = 1'b0;
        ballDR = '0;
        for (int i = 0; i < NB; i++) set_ball(i, 100 + 100*i, 200, 3 + i, -2 - i);
        cycle();
        cycle();
        check("rst_coll", coll3, 0);
        check("rst_vx", vxo3, 0);
        resetN = 1'b1;
        cycle();

        // Left hit with damping
        set_ball(0, 30, 200, -8, 5);
        bordersDR = 1'b1;
        ballDR = 4'b0001;
        cycle();
        check("t1_pulse", coll3[0], 1);
        check("t1_edge", edge3[3:0], 4'b0010);
        check("t1_vx", $signed(vxo3[0 +: W]), 7);
        check("t1_vy", $signed(vyo3[0 +: W]), 5);
        ballDR = '0;
        cycle();
        check("t1_pulse_off", coll3[0], 0);
        check("t1_hold", $signed(vxo3[0 +: W]), 7);
        startOfFrame = 1'b1;
        cycle();
        startOfFrame = 1'b0;
        cycle();
        check("t1_follow", $signed(vxo3[0 +: W]), -8);

        // Corner hit
        set_ball(0, 300, 200, -8, 5);
        cycle();
        set_ball(0, 30, 30, -4, -16);
        ballDR = 4'b0001;
        cycle();
        check("t3_edge", edge3[3:0], 4'b1010);
        check("t3_vx", $signed(vxo3[0 +: W]), 4);
        check("t3_vy", $signed(vyo3[0 +: W]), 14);

        // No re-trigger while latched; re-arm once clear of the borders
        ballDR = '0;
        set_ball(0, 31, 30, -4, -16);
        cycle();
        ballDR = 4'b0001;
        cycle();
        check("t4_no_repulse", coll3[0], 0);
        ballDR = '0;
        set_ball(0, 40, 200, -4, -16);
        cycle();
        cycle();
        set_ball(0, 30, 200, -4, -16);
        ballDR = 4'b0001;
        cycle();
        check("t4_repulse", coll3[0], 1);
        ballDR = '0;
        cycle();

        // Right hit, undamped instance, held until startOfFrame
        set_ball(1, 600, 200, 5, 1);
        ballDR = 4'b0010;
        cycle();
        check("t2_vx0", $signed(vxo0[W +: W]), -5);
        check("t2_edge", edge0[7:4], 4'b0001);
        ballDR = '0;
        set_ball(1, 600, 200, 9, 1);
        cycle();
        check("t2_hold", $signed(vxo0[W +: W]), -5);
        cycle();
        startOfFrame = 1'b1;
        cycle();
        startOfFrame = 1'b0;
        check("t2_follow", $signed(vxo0[W +: W]), 9);

        // Two balls hit in the same cycle as startOfFrame
        set_ball(1, 300, 200, 6, -3);
        set_ball(0, 300, 200, -8, 2);
        cycle();
        set_ball(0, 30, 200, -8, 2);
        set_ball(3, 600, 200, 16, -1);
        ballDR = 4'b1001;
        startOfFrame = 1'b1;
        cycle();
        startOfFrame = 1'b0;
        ballDR = '0;
        check("t5_pulses", coll3, 4'b1001);
        check("t5_b0_vx", $signed(vxo3[0 +: W]), 7);
        check("t5_b3_vx", $signed(vxo3[3*W +: W]), -14);
        check("t5_b1_pass", $signed(vxo3[W +: W]), 6);
        check("t5_b2_pass", $signed(vxo3[2*W +: W]), 5);
        cycle();
        check("t5_b3_hold", $signed(vxo3[3*W +: W]), -14);

        // Most negative velocity, then reset in the middle of the hold
        set_ball(0, 300, 200, 0, 0);
        cycle();
        set_ball(0, 30, 200, -1024, 0);
        ballDR = 4'b0001;
        cycle();
        ballDR = '0;
        check("t6_vx_d3", $signed(vxo3[0 +: W]), 896);
        check("t6_vx_d0", $signed(vxo0[0 +: W]), 1023);
        cycle();
        resetN = 1'b0;
        #1;
        check("t6_rst_vx", vxo3, 0);
        check("t6_rst_vx0", vxo0, 0);
        check("t6_rst_edge", edge3, 0);
        check("t6_rst_coll", coll3, 0);
        cycle();
        resetN = 1'b1;
        set_ball(0, 30, 200, -8, 0);
        ballDR = 4'b0001;
        cycle();
        check("t6_armed", coll3[0], 1);
        ballDR = '0;
        cycle();

        // Random traffic against the model
        for (int n = 0; n < 80; n++) begin
            for (int i = 0; i < NB; i++)
                set_ball(i, int'($urandom_range(0, 700)), int'($urandom_range(0, 500)),
                         int'($urandom_range(0, 2047)) - 1024,
                         int'($urandom_range(0, 2047)) - 1024);
            ballDR = NB'($urandom_range(0, 15));
            bordersDR = ($urandom_range(0, 3) != 0);
            startOfFrame = ($urandom_range(0, 7) == 0);
            cycle();
        end

        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
